// File: rtl/snn_cfg_pkg.sv
// Shared FSM type, byte-map offsets and sizing helpers for the SNN configuration controller.
// Layout: input bytes, decay, refractory, threshold, div, weights, delays, debug.
package snn_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  function automatic int ceil8(input int bits);
    return (bits + 7) / 8;
  endfunction

  function automatic int calcNSyn(input int nIn, input int nHid, input int nOut);
    return nIn * nHid + nHid * nOut;
  endfunction

  function automatic int calcOffDecay(input int nIn);
    return ceil8(nIn);
  endfunction

  function automatic int calcOffW(input int nIn);
    return ceil8(nIn) + 4;
  endfunction

  function automatic int calcOffD(input int nIn, input int nHid, input int nOut, input int wBits);
    return calcOffW(nIn) + ceil8(calcNSyn(nIn, nHid, nOut) * wBits);
  endfunction

  function automatic int calcOffDbg(input int nIn, input int nHid, input int nOut,
                                    input int wBits, input int dBits);
    return calcOffD(nIn, nHid, nOut, wBits) + ceil8(calcNSyn(nIn, nHid, nOut) * dBits);
  endfunction

  function automatic int calcNBytes(input int nIn, input int nHid, input int nOut,
                                    input int wBits, input int dBits);
    return calcOffDbg(nIn, nHid, nOut, wBits, dBits) + 1;
  endfunction

  localparam int DEF_N_IN   = 16;
  localparam int DEF_N_HID  = 8;
  localparam int DEF_N_OUT  = 2;
  localparam int DEF_W_BITS = 2;
  localparam int DEF_D_BITS = 4;
  localparam int DEF_P_BITS = 6;

  localparam int OFF_DECAY = calcOffDecay(DEF_N_IN);
  localparam int OFF_W     = calcOffW(DEF_N_IN);
  localparam int OFF_D     = calcOffD(DEF_N_IN, DEF_N_HID, DEF_N_OUT, DEF_W_BITS);
  localparam int OFF_DBG   = calcOffDbg(DEF_N_IN, DEF_N_HID, DEF_N_OUT, DEF_W_BITS, DEF_D_BITS);
  localparam int NBYTES    = calcNBytes(DEF_N_IN, DEF_N_HID, DEF_N_OUT, DEF_W_BITS, DEF_D_BITS);

endpackage

// File: rtl/snn_cfg_ctrl_if.sv
// Byte-write/readback bus plus the committed parameter and timestep outputs of snn_cfg_ctrl.
interface snn_cfg_ctrl_if
  import snn_cfg_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_HID  = DEF_N_HID,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int W_BITS = DEF_W_BITS,
  parameter int D_BITS = DEF_D_BITS,
  parameter int P_BITS = DEF_P_BITS
) ();

  localparam int N_SYN  = calcNSyn(N_IN, N_HID, N_OUT);
  localparam int ADDR_W = $clog2(calcNBytes(N_IN, N_HID, N_OUT, W_BITS, D_BITS));

  logic                     wr_valid;
  logic                     wr_ready;
  logic [ADDR_W-1:0]        wr_addr;
  logic [7:0]               wr_data;
  logic [ADDR_W-1:0]        rd_addr;
  logic [7:0]               rd_data;
  logic                     commit;
  logic                     commit_done;
  logic                     cfg_valid;
  logic                     input_ready;
  logic                     snn_enable;
  logic [N_IN-1:0]          input_spikes;
  logic [P_BITS-1:0]        decay;
  logic [P_BITS-1:0]        refractory_period;
  logic [P_BITS-1:0]        threshold;
  logic [7:0]               div_value;
  logic [N_SYN*W_BITS-1:0]  weights;
  logic [N_SYN*D_BITS-1:0]  delays;
  logic [7:0]               debug_config;
  logic [15:0]              step_count;
  logic                     addr_err;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_addr, commit, input_ready,
    input  wr_ready, rd_data, commit_done, cfg_valid, snn_enable, input_spikes,
           decay, refractory_period, threshold, div_value, weights, delays,
           debug_config, step_count, addr_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_addr, commit, input_ready,
    output wr_ready, rd_data, commit_done, cfg_valid, snn_enable, input_spikes,
           decay, refractory_period, threshold, div_value, weights, delays,
           debug_config, step_count, addr_err
  );

endinterface

// File: rtl/snn_cfg_regfile.sv
// Double-buffered byte register bank: writable shadow copy, active copy loaded on copy_i,
// and a registered shadow readback port.
module snn_cfg_regfile #(
  parameter int NBYTES = 115,
  parameter int ADDR_W = $clog2(NBYTES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrEn_i,
  input  logic [ADDR_W-1:0]     wrAddr_i,
  input  logic [7:0]            wrData_i,
  input  logic                  copy_i,
  input  logic [ADDR_W-1:0]     rdAddr_i,
  output logic [7:0]            rdData_o,
  output logic [NBYTES*8-1:0]   shadow_o,
  output logic [NBYTES*8-1:0]   active_o
);

  logic [7:0] shadow_q [NBYTES];
  logic [7:0] active_q [NBYTES];
  logic [7:0] rdData_q;
  logic [7:0] rdData_d;

  // Addresses past the end of the bank read back as zero.
  always_comb begin
    rdData_d = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (rdAddr_i == ADDR_W'(i)) rdData_d = shadow_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdData_q <= '0;
      for (int i = 0; i < NBYTES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      rdData_q <= rdData_d;
      for (int i = 0; i < NBYTES; i++) begin
        if (wrEn_i && (wrAddr_i == ADDR_W'(i))) shadow_q[i] <= wrData_i;
        if (copy_i) active_q[i] <= shadow_q[i];
      end
    end
  end

  assign rdData_o = rdData_q;

  for (genvar g = 0; g < NBYTES; g++) begin : g_flat
    assign shadow_o[g*8 +: 8] = shadow_q[g];
    assign active_o[g*8 +: 8] = active_q[g];
  end

endmodule

// File: rtl/snn_cfg_ctrl.sv
// SNN configuration and timestep controller: atomic parameter commit from a shadow bank
// and frame-gated single-cycle step pulses toward the core.
module snn_cfg_ctrl
  import snn_cfg_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_HID  = DEF_N_HID,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int W_BITS = DEF_W_BITS,
  parameter int D_BITS = DEF_D_BITS,
  parameter int P_BITS = DEF_P_BITS
) (
  input logic           clk,
  input logic           reset,
  snn_cfg_ctrl_if.slave bus
);

  localparam int IN_B      = ceil8(N_IN);
  localparam int N_SYN     = calcNSyn(N_IN, N_HID, N_OUT);
  localparam int DECAY_AT  = calcOffDecay(N_IN);
  localparam int W_AT      = calcOffW(N_IN);
  localparam int D_AT      = calcOffD(N_IN, N_HID, N_OUT, W_BITS);
  localparam int DBG_AT    = calcOffDbg(N_IN, N_HID, N_OUT, W_BITS, D_BITS);
  localparam int NUM_BYTES = calcNBytes(N_IN, N_HID, N_OUT, W_BITS, D_BITS);
  localparam int ADDR_W    = $clog2(NUM_BYTES);

  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(NUM_BYTES);
  localparam logic [ADDR_W-1:0] LAST_IN    = ADDR_W'(IN_B - 1);

  state_e state_q, state_d;
  logic framePending_q, framePending_d;
  logic cfgValid_q, commitDone_q, snnEnable_q, addrErr_q;
  logic [15:0] stepCount_q;
  logic [N_IN-1:0] inputSpikes_q;

  logic wrAccept, wrInRange, wrEn, lastInWrite, stepGo, enterStep, copyEn;
  logic [NUM_BYTES*8-1:0] shadowFlat, activeFlat;
  logic unusedBits;

  assign bus.wr_ready = (state_q != ST_COMMIT);
  assign wrAccept     = bus.wr_valid & bus.wr_ready;
  assign wrInRange    = ({1'b0, bus.wr_addr} < ADDR_LIMIT);
  assign wrEn         = wrAccept & wrInRange;
  assign lastInWrite  = wrAccept & (bus.wr_addr == LAST_IN);
  assign stepGo       = framePending_q & bus.input_ready & cfgValid_q;
  assign copyEn       = (state_q == ST_COMMIT);

  // A commit request always wins over a step that is ready in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.commit)  state_d = ST_COMMIT;
        else if (stepGo) state_d = ST_STEP;
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_STEP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign enterStep = (state_q == ST_IDLE) && (state_d == ST_STEP);

  // A last-input-byte write racing the step keeps the new frame pending.
  always_comb begin
    framePending_d = framePending_q;
    if (enterStep)   framePending_d = 1'b0;
    if (lastInWrite) framePending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      framePending_q <= 1'b0;
      cfgValid_q     <= 1'b0;
      commitDone_q   <= 1'b0;
      snnEnable_q    <= 1'b0;
      addrErr_q      <= 1'b0;
      stepCount_q    <= '0;
      inputSpikes_q  <= '0;
    end else begin
      state_q        <= state_d;
      framePending_q <= framePending_d;
      cfgValid_q     <= cfgValid_q | copyEn;
      commitDone_q   <= copyEn;
      snnEnable_q    <= enterStep;
      addrErr_q      <= addrErr_q | (wrAccept & ~wrInRange);
      if (enterStep) begin
        stepCount_q   <= stepCount_q + 16'd1;
        inputSpikes_q <= shadowFlat[N_IN-1:0];
      end
    end
  end

  snn_cfg_regfile #(
    .NBYTES (NUM_BYTES),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wrEn_i   (wrEn),
    .wrAddr_i (bus.wr_addr),
    .wrData_i (bus.wr_data),
    .copy_i   (copyEn),
    .rdAddr_i (bus.rd_addr),
    .rdData_o (bus.rd_data),
    .shadow_o (shadowFlat),
    .active_o (activeFlat)
  );

  assign bus.commit_done       = commitDone_q;
  assign bus.cfg_valid         = cfgValid_q;
  assign bus.snn_enable        = snnEnable_q;
  assign bus.input_spikes      = inputSpikes_q;
  assign bus.step_count        = stepCount_q;
  assign bus.addr_err          = addrErr_q;
  assign bus.decay             = activeFlat[DECAY_AT*8 +: P_BITS];
  assign bus.refractory_period = activeFlat[(DECAY_AT+1)*8 +: P_BITS];
  assign bus.threshold         = activeFlat[(DECAY_AT+2)*8 +: P_BITS];
  assign bus.div_value         = activeFlat[(DECAY_AT+3)*8 +: 8];
  assign bus.weights           = activeFlat[W_AT*8 +: N_SYN*W_BITS];
  assign bus.delays            = activeFlat[D_AT*8 +: N_SYN*D_BITS];
  assign bus.debug_config      = activeFlat[DBG_AT*8 +: 8];

  // Padding bits of partially used bytes are stored but never drive an output.
  assign unusedBits = ^{shadowFlat, activeFlat};

endmodule
